// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: two-port req/gnt arbiter and sequencer for the shared 8-bit ALU.
// Grants one requester at a time, drives the ALU for ALU_LAT cycles, then returns
// the captured 16-bit result with a one-cycle valid pulse to the winner.
// Optional feature: define ALU_ARB_RR_EN for round-robin tie-break; when undefined,
// requester 0 always wins simultaneous requests.
module alu_req_arbiter #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [3:0]  op0,
    input  logic [3:0]  op1,
    input  logic [7:0]  a0,
    input  logic [7:0]  a1,
    input  logic [7:0]  b0,
    input  logic [7:0]  b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rsp_valid0,
    output logic        rsp_valid1,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic [3:0]  alu_opcode,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_init,
    output logic        alu_ex_sel,
    input  logic [15:0] alu_result
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] CNT_LAST = 4'(ALU_LAT - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        rsp_valid0_q, rsp_valid0_d;
    logic        rsp_valid1_q, rsp_valid1_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic [3:0]  alu_opcode_q, alu_opcode_d;
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
    logic        alu_init_q;
    logic        winner_q, winner_d;

    logic        any_req;
    logic        pick1;
    logic [15:0] cap_data;
    logic        cap_err;

    assign any_req = req0 | req1;

`ifdef ALU_ARB_RR_EN
    logic last_q;

    // Winner select: a lone requester wins; a tie goes to the one not served last
    always_comb pick1 = req1 & (~req0 | last_q == 1'b0);

    // Last-winner pointer; reset value makes requester 0 win the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (state_q == IDLE && any_req) begin
            last_q <= pick1;
        end
    end
`else
    // Winner select: fixed priority, requester 0 wins ties
    always_comb pick1 = req1 & ~req0;
`endif

    // Response decode: masked opcodes float the ALU bus, so never sample it there
    always_comb begin
        cap_data = alu_result;
        cap_err  = 1'b0;
        case (alu_opcode_q)
            4'b0000, 4'b1011: begin
                cap_data = 16'h0000;
                cap_err  = 1'b0;
            end
            4'b1111: begin
                cap_data = 16'h0000;
                cap_err  = 1'b1;
            end
            default: begin
                cap_data = alu_result;
                cap_err  = 1'b0;
            end
        endcase
    end

    // Sequencer next-state: IDLE grants, EXEC counts out the ALU latency, DONE responds
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        rsp_valid0_d = 1'b0;
        rsp_valid1_d = 1'b0;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        winner_d     = winner_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt0_d       = ~pick1;
                    gnt1_d       = pick1;
                    winner_d     = pick1;
                    alu_opcode_d = pick1 ? op1 : op0;
                    alu_a_d      = pick1 ? a1 : a0;
                    alu_b_d      = pick1 ? b1 : b0;
                    cnt_d        = '0;
                    state_d      = EXEC;
                end else begin
                    alu_opcode_d = 4'b0000;
                end
            end
            EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    rsp_data_d   = cap_data;
                    rsp_err_d    = cap_err;
                    rsp_valid0_d = ~winner_q;
                    rsp_valid1_d = winner_q;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                alu_opcode_d = 4'b0000;
                state_d      = IDLE;
            end
            default: begin
                alu_opcode_d = 4'b0000;
                state_d      = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_init_q   <= 1'b0;
            winner_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            rsp_valid0_q <= rsp_valid0_d;
            rsp_valid1_q <= rsp_valid1_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_init_q   <= 1'b1;
            winner_q     <= winner_d;
        end
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign rsp_valid0 = rsp_valid0_q;
    assign rsp_valid1 = rsp_valid1_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != IDLE);
    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_init   = alu_init_q;
    assign alu_ex_sel = 1'b0;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: scoreboard bench for alu_req_arbiter.
// Instance 0 runs with ALU_LAT=1, instance 1 with ALU_LAT=3; a behavioural ALU
// feeds each. Expected responses are queued at issue time and popped by a monitor.
// Tie expectations follow ALU_ARB_RR_EN.
module tb_alu_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_s [2];
    logic        req1_s [2];
    logic [3:0]  op0_s [2];
    logic [3:0]  op1_s [2];
    logic [7:0]  a0_s [2];
    logic [7:0]  a1_s [2];
    logic [7:0]  b0_s [2];
    logic [7:0]  b1_s [2];
    logic        gnt0_s [2];
    logic        gnt1_s [2];
    logic        rv0_s [2];
    logic        rv1_s [2];
    logic [15:0] rsp_data_s [2];
    logic        rsp_err_s [2];
    logic        busy_s [2];
    logic [3:0]  alu_opcode_s [2];
    logic [7:0]  alu_a_s [2];
    logic [7:0]  alu_b_s [2];
    logic        alu_init_s [2];
    logic        alu_ex_sel_s [2];
    logic [15:0] alu_res_s [2];

    typedef struct {
        int          inst;
        logic        port;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q [$];
    int   gcyc_q [$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_rsp = 0;
    int   n_push = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU; masked/unsupported opcodes return garbage to expose any pass-through
    function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic init);
        if (!init) return 16'hxxxx;
        case (op)
            4'h1:    return {8'h00, a} + {8'h00, b};
            4'h2:    return {8'h00, a} - {8'h00, b};
            4'h3:    return {8'h00, a} * {8'h00, b};
            4'h5:    return {8'h00, a & b};
            4'hC:    return {8'h00, b} << (a - 8'd4);
            4'h0:    return 16'hBAD0;
            4'hB:    return 16'hBAD0;
            4'hF:    return 16'hDEAD;
            default: return {a, b} ^ 16'h5A5A;
        endcase
    endfunction

    assign alu_res_s[0] = alu_f(alu_opcode_s[0], alu_a_s[0], alu_b_s[0], alu_init_s[0]);
    assign alu_res_s[1] = alu_f(alu_opcode_s[1], alu_a_s[1], alu_b_s[1], alu_init_s[1]);

    alu_req_arbiter #(.ALU_LAT(1)) u_dut_lat1 (
        .clk(clk), .rst(rst),
        .req0(req0_s[0]), .req1(req1_s[0]), .op0(op0_s[0]), .op1(op1_s[0]),
        .a0(a0_s[0]), .a1(a1_s[0]), .b0(b0_s[0]), .b1(b1_s[0]),
        .gnt0(gnt0_s[0]), .gnt1(gnt1_s[0]), .rsp_valid0(rv0_s[0]), .rsp_valid1(rv1_s[0]),
        .rsp_data(rsp_data_s[0]), .rsp_err(rsp_err_s[0]), .busy(busy_s[0]),
        .alu_opcode(alu_opcode_s[0]), .alu_a(alu_a_s[0]), .alu_b(alu_b_s[0]),
        .alu_init(alu_init_s[0]), .alu_ex_sel(alu_ex_sel_s[0]), .alu_result(alu_res_s[0])
    );

    alu_req_arbiter #(.ALU_LAT(3)) u_dut_lat3 (
        .clk(clk), .rst(rst),
        .req0(req0_s[1]), .req1(req1_s[1]), .op0(op0_s[1]), .op1(op1_s[1]),
        .a0(a0_s[1]), .a1(a1_s[1]), .b0(b0_s[1]), .b1(b1_s[1]),
        .gnt0(gnt0_s[1]), .gnt1(gnt1_s[1]), .rsp_valid0(rv0_s[1]), .rsp_valid1(rv1_s[1]),
        .rsp_data(rsp_data_s[1]), .rsp_err(rsp_err_s[1]), .busy(busy_s[1]),
        .alu_opcode(alu_opcode_s[1]), .alu_a(alu_a_s[1]), .alu_b(alu_b_s[1]),
        .alu_init(alu_init_s[1]), .alu_ex_sel(alu_ex_sel_s[1]), .alu_result(alu_res_s[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input string why);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (t=%0t)", name, why, $time);
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Monitor: records grant cycles and checks every response against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        int   g;
        for (int i = 0; i < 2; i++) begin
            if (rv0_s[i] || rv1_s[i]) begin
                n_rsp++;
                check("rsp_onehot", 64'(rv0_s[i] & rv1_s[i]), 64'd0);
                check("rsp_known", 64'($isunknown(rsp_data_s[i])), 64'd0);
                if (exp_q.size() == 0) begin
                    fail("rsp_unexpected", $sformatf("inst %0d data 0x%0h", i, rsp_data_s[i]));
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_inst", 64'(i), 64'(e.inst));
                    check("rsp_port", 64'(rv1_s[i]), 64'(e.port));
                    check("rsp_data", 64'(rsp_data_s[i]), 64'(e.data));
                    check("rsp_err", 64'(rsp_err_s[i]), 64'(e.err));
                end
                if (gcyc_q.size() == 0) begin
                    fail("rsp_no_grant", $sformatf("inst %0d", i));
                end else begin
                    g = gcyc_q.pop_front();
                    check("rsp_latency", 64'(cyc - g), 64'(lat_of(i)));
                end
            end
            if (gnt0_s[i] || gnt1_s[i]) gcyc_q.push_back(cyc);
        end
    end

    task automatic push(input int inst, input logic port, input logic [15:0] data, input logic err);
        exp_t e;
        e.inst = inst;
        e.port = port;
        e.data = data;
        e.err  = err;
        exp_q.push_back(e);
        n_push++;
    endtask

    task automatic drive(input int inst, input int port, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b);
        if (port == 0) begin
            req0_s[inst] = 1'b1; op0_s[inst] = op; a0_s[inst] = a; b0_s[inst] = b;
        end else begin
            req1_s[inst] = 1'b1; op1_s[inst] = op; a1_s[inst] = a; b1_s[inst] = b;
        end
    endtask

    task automatic drop(input int inst, input int port);
        if (port == 0) req0_s[inst] = 1'b0;
        else req1_s[inst] = 1'b0;
    endtask

    function automatic logic gnt_of(input int inst, input int port);
        return (port == 0) ? gnt0_s[inst] : gnt1_s[inst];
    endfunction

    task automatic wait_gnt(input int inst, input int port, output int g);
        bit seen;
        seen = 1'b0;
        g = -1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (gnt_of(inst, port)) begin
                seen = 1'b1;
                g = cyc;
            end
        end
        if (!seen) fail("gnt_timeout", $sformatf("inst %0d port %0d", inst, port));
    endtask

    // Queue the expectation, request, wait for the grant, release, check the pulse width
    task automatic issue(input int inst, input int port, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_data, input logic exp_err, output int g);
        push(inst, port[0], exp_data, exp_err);
        drive(inst, port, op, a, b);
        wait_gnt(inst, port, g);
        drop(inst, port);
        @(negedge clk);
        check("gnt_one_cycle", 64'(gnt_of(inst, port)), 64'd0);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) fail("drain_timeout", $sformatf("%0d responses missing", exp_q.size()));
    endtask

    task automatic check_reset(input int i);
        check("reset_outputs",
              64'({gnt0_s[i], gnt1_s[i], rv0_s[i], rv1_s[i], rsp_data_s[i], rsp_err_s[i],
                   busy_s[i], alu_opcode_s[i], alu_a_s[i], alu_b_s[i], alu_init_s[i],
                   alu_ex_sel_s[i]}), 64'd0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        gcyc_q.delete();
        @(negedge clk);
        check("init_rise", 64'({alu_init_s[0], alu_init_s[1]}), 64'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   g, g2, r0, ng;
        logic tie_port [4];
        int   tie_cyc [4];
        logic exp_p;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req0_s[i] = 1'b0; req1_s[i] = 1'b0;
            op0_s[i] = '0; op1_s[i] = '0; a0_s[i] = '0; a1_s[i] = '0; b0_s[i] = '0; b1_s[i] = '0;
        end
        @(negedge clk);
        do_reset(2);

        // Single op, LAT=1: 10+20
        issue(0, 0, 4'h1, 8'd10, 8'd20, 16'd30, 1'b0, g);
        @(negedge clk);
        check("single_busy_low", 64'(busy_s[0]), 64'd0);
        check("single_opcode_idle", 64'(alu_opcode_s[0]), 64'd0);
        drain();

        // Tie with both requests held, from a fresh pointer
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
            exp_p = k[0];
`else
            exp_p = 1'b0;
`endif
            push(0, exp_p, exp_p ? 16'hFFFC : 16'd255, 1'b0);
        end
        drive(0, 0, 4'h3, 8'd15, 8'd17);
        drive(0, 1, 4'h2, 8'd5, 8'd9);
        ng = 0;
        for (int k = 0; k < 60 && ng < 4; k++) begin
            @(negedge clk);
            if (gnt0_s[0] || gnt1_s[0]) begin
                check("tie_gnt_onehot", 64'(gnt0_s[0] & gnt1_s[0]), 64'd0);
                tie_port[ng] = gnt1_s[0];
                tie_cyc[ng]  = cyc;
                ng++;
            end
        end
        drop(0, 0);
        drop(0, 1);
        check("tie_grant_count", 64'(ng), 64'd4);
        for (int k = 0; k < ng; k++) begin
`ifdef ALU_ARB_RR_EN
            exp_p = k[0];
`else
            exp_p = 1'b0;
`endif
            check("tie_order", 64'(tie_port[k]), 64'(exp_p));
            if (k > 0) check("tie_spacing", 64'(tie_cyc[k] - tie_cyc[k-1]), 64'd3);
        end
        drain();

        // Masked and unsupported opcodes
        issue(0, 0, 4'hB, 8'h12, 8'h34, 16'h0000, 1'b0, g);
        drain();
        issue(0, 0, 4'h0, 8'h56, 8'h78, 16'h0000, 1'b0, g);
        drain();
        issue(0, 0, 4'hF, 8'h9A, 8'hBC, 16'h0000, 1'b1, g);
        drain();

        // LAT=3: op 1100, then a second op queued during EXEC
        issue(1, 1, 4'hC, 8'd9, 8'd4, 16'h0080, 1'b0, g);
        issue(1, 0, 4'h1, 8'd3, 8'd4, 16'd7, 1'b0, g2);
        check("b2b_spacing", 64'(g2 - g), 64'd5);
        drain();

        // Reset during EXEC abandons the op silently
        drive(0, 0, 4'h1, 8'd40, 8'd2);
        wait_gnt(0, 0, g);
        drop(0, 0);
        r0 = n_rsp;
        do_reset(1);
        repeat (4) @(negedge clk);
        check("abort_no_rsp", 64'(n_rsp), 64'(r0));
        issue(0, 1, 4'h5, 8'hF0, 8'h3C, 16'h0030, 1'b0, g);
        drain();

        // Late request raised while busy and held
        r0 = n_rsp;
        issue(0, 0, 4'h1, 8'd1, 8'd2, 16'd3, 1'b0, g);
        check("late_raised_busy", 64'(busy_s[0]), 64'd1);
        issue(0, 1, 4'h2, 8'd9, 8'd5, 16'd4, 1'b0, g2);
        check("late_gnt_timing", 64'(g2 - g), 64'd3);
        drain();
        repeat (3) @(negedge clk);
        check("late_rsp_count", 64'(n_rsp - r0), 64'd2);

        check("total_rsp_count", 64'(n_rsp), 64'(n_push));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
